ifetch_unit: RTL and testbench

Instruction fetch unit for the single-cycle RV32I core. Holds the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents the fetched instruction and its decoded fields (opcode, func3, func7) to the control unit. It accepts a redirect target from the core's branch/jump resolution, which is driven by the control unit's sb/uj/jalr_i outputs.

---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/ifetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_ifetch_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I single-cycle core front end:
//   - datapath width and instruction field widths
//   - base opcode constants used by the control unit
//   - canonical NOP encoding (addi x0, x0, 0)
//   - the instruction fetch state enum
//   - decoded field payload carried from fetch to control
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned OPCODE_W     = 7;
  localparam int unsigned FUNC3_W      = 3;
  localparam int unsigned FUNC7_W      = 1;
  localparam int unsigned FETCH_STATE_W = 3;

  // Base opcodes (instr[6:0])
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b011_0011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b001_0011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b000_0011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b010_0011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b110_0011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b110_1111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b110_0111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b011_0111;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Fetch sequencer states
  typedef enum logic [FETCH_STATE_W-1:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_HOLD  = 3'd2,
    FS_FLUSH = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_t;

  // Decoded fields presented to the control unit alongside the instruction
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic [FUNC7_W-1:0]  func7;
  } instr_fields_t;

  // A fetch target is legal only on a 4-byte boundary
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage : rv32i_pkg

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch unit for the single-cycle RV32I core. Owns the program
// counter, fetches one 32-bit word at a time from instruction memory over a
// req/ack handshake, holds the fetched word until the core consumes it, and
// follows redirects coming from branch/jump resolution.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset, highest priority
//   imem_req      fetch request, stable with imem_addr until acked
//   imem_addr     word-aligned fetch address
//   imem_ack      memory response valid (ignored while imem_req=0)
//   imem_rdata    instruction word returned with imem_ack
//   instr_valid   instr/pc/fields hold a valid instruction
//   instr         held instruction word
//   pc            address of the held instruction
//   pc_plus4      pc + 4 (wraps mod 2^32)
//   opcode        instr[6:0]
//   func3         instr[14:12]
//   func7         instr[30]
//   instr_ready   core consumes the held instruction this cycle
//   redirect      take redirect_pc as the next fetch address
//   redirect_pc   branch/jump target
//   misalign_err  sticky flag, a redirect target was not word-aligned
// ---------------------------------------------------------------------------
module ifetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,

  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     imem_rdata,

  output logic                instr_valid,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC3_W-1:0]  func3,
  output logic [FUNC7_W-1:0]  func7,
  input  logic                instr_ready,

  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                misalign_err
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Registered state
  fetch_state_t    state_q,       state_d;
  logic [XLEN-1:0] pc_q,          pc_d;
  logic [XLEN-1:0] pend_pc_q,     pend_pc_d;
  logic [XLEN-1:0] instr_q,       instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q,    imem_req_d;
  logic            misalign_q,    misalign_d;

  logic            redirect_bad;
  instr_fields_t   fields;

  // Misaligned targets are fatal; they stop fetch without touching pc
  assign redirect_bad = redirect && !is_word_aligned(redirect_pc[1:0]);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    misalign_d    = misalign_q;

    unique case (state_q)
      // Redirect is ignored here; fetch always starts at the current pc
      FS_IDLE: begin
        state_d    = FS_REQ;
        imem_req_d = 1'b1;
      end

      // Request outstanding at pc; imem_addr tracks pc_q
      FS_REQ: begin
        if (redirect_bad) begin
          state_d       = FS_HALT;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b0;
          misalign_d    = 1'b1;
        end else if (imem_ack) begin
          if (redirect) begin
            // Returned word belongs to the abandoned path
            pc_d = redirect_pc;
          end else begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            imem_req_d    = 1'b0;
            state_d       = FS_HOLD;
          end
        end else if (redirect) begin
          // Address must stay stable until ack, so park the target
          pend_pc_d = redirect_pc;
          state_d   = FS_FLUSH;
        end
      end

      // Draining a stale request; its data is discarded on ack
      FS_FLUSH: begin
        if (redirect_bad) begin
          state_d       = FS_HALT;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b0;
          misalign_d    = 1'b1;
        end else if (imem_ack) begin
          pc_d    = redirect ? redirect_pc : pend_pc_q;
          state_d = FS_REQ;
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
        end
      end

      // Instruction presented to the core; redirect outranks consume
      FS_HOLD: begin
        if (redirect_bad) begin
          state_d       = FS_HALT;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b0;
          misalign_d    = 1'b1;
        end else if (redirect) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = FS_REQ;
        end else if (instr_ready) begin
          pc_d          = pc_q + PC_STEP;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = FS_REQ;
        end
      end

      // Terminal until reset
      FS_HALT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        misalign_d    = 1'b1;
      end

      default: begin
        state_d       = FS_IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= '0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      misalign_q    <= misalign_d;
    end
  end

  // Field extraction is plain wiring off the instruction register
  assign fields.opcode = instr_q[6:0];
  assign fields.func3  = instr_q[14:12];
  assign fields.func7  = instr_q[30];

  // The fetch address is the pc register; it only moves on ack or in HOLD,
  // so it is stable for the whole life of a request
  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + PC_STEP;
  assign opcode       = fields.opcode;
  assign func3        = fields.func3;
  assign func7        = fields.func7;
  assign misalign_err = misalign_q;

endmodule : ifetch_unit

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Directed scenarios followed by random traffic, all compared cycle by cycle
// against a transaction-level reference model of the fetch unit.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [0:0]  func7;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch-transaction view of the unit
  bit          m_init    = 0;  // model has seen a reset
  bit          m_started = 0;  // first request issued since reset
  bit          m_busy    = 0;  // a memory request is outstanding
  bit          m_drop    = 0;  // outstanding response belongs to a dead path
  bit          m_halt    = 0;  // misaligned redirect seen
  bit          m_valid   = 0;  // an instruction is held for the core
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_pend    = 32'h0;
  logic [31:0] m_instr   = 32'h0000_0013;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("req",      32'(imem_req),     32'(m_busy));
    if (m_busy) chk("addr", imem_addr, m_pc);
    chk("valid",    32'(instr_valid),  32'(m_valid));
    chk("instr",    instr,             m_instr);
    chk("pc",       pc,                m_pc);
    chk("pc_plus4", pc_plus4,          m_pc + 32'd4);
    chk("opcode",   32'(opcode),       32'(m_instr[6:0]));
    chk("func3",    32'(func3),        32'(m_instr[14:12]));
    chk("func7",    32'(func7),        32'(m_instr[30]));
    chk("misalign", 32'(misalign_err), 32'(m_halt));
  endtask

  // Advance the model by one clock with the given inputs
  task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                            input logic rdy, input logic rd, input logic [31:0] rp);
    bit bad;
    bad = rd && (rp[1:0] != 2'b00);
    if (r) begin
      m_init = 1; m_started = 0; m_busy = 0; m_drop = 0; m_halt = 0;
      m_valid = 0; m_pc = 32'h0; m_pend = 32'h0; m_instr = 32'h0000_0013;
    end else if (m_init && !m_halt) begin
      if (!m_started) begin
        m_started = 1;
        m_busy    = 1;
      end else if (m_valid) begin
        if (bad) begin
          m_halt = 1; m_valid = 0;
        end else if (rd) begin
          m_pc = rp; m_valid = 0; m_busy = 1;
        end else if (rdy) begin
          m_pc = m_pc + 32'd4; m_valid = 0; m_busy = 1;
        end
      end else if (m_busy) begin
        if (bad) begin
          m_halt = 1; m_busy = 0; m_drop = 0;
        end else if (a) begin
          if (m_drop) begin
            m_pc   = rd ? rp : m_pend;
            m_drop = 0;
          end else if (rd) begin
            m_pc = rp;
          end else begin
            m_instr = d; m_valid = 1; m_busy = 0;
          end
        end else if (rd) begin
          m_pend = rp;
          m_drop = 1;
        end
      end
    end
  endtask

  // One clock: check current outputs, apply inputs, advance model and DUT
  task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                     input logic rdy, input logic rd, input logic [31:0] rp);
    if (m_init) compare_model();
    rst         = r;
    imem_ack    = a;
    imem_rdata  = d;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rp;
    model_step(r, a, d, rdy, rd, rp);
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_req",   32'(imem_req),     32'd0);
    chk("rst_valid", 32'(instr_valid),  32'd0);
    chk("rst_instr", instr,             NOP);
    chk("rst_pc",    pc,                32'h0);
    chk("rst_mis",   32'(misalign_err), 32'd0);

    // Zero-wait memory: addresses 0, 4, 8, one instruction per two cycles
    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("seq_req",  32'(imem_req), 32'd1);
      chk("seq_addr", imem_addr,     32'(k * 4));
      cyc(0, 1, NOP, 0, 0, 0);
      chk("seq_valid", 32'(instr_valid), 32'd1);
      chk("seq_pc",    pc,               32'(k * 4));
      chk("seq_pc4",   pc_plus4,         32'(k * 4 + 4));
      cyc(0, 0, 0, 1, 0, 0);
    end

    // Ack delayed three cycles at 0x10
    cyc(0, 1, NOP, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 3; j++) begin
      chk("wait_req",  32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr,     32'h10);
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk("wait_req4",  32'(imem_req), 32'd1);
    chk("wait_addr4", imem_addr,     32'h10);
    cyc(0, 1, 32'h4020_8133, 0, 0, 0);
    chk("fld_valid",  32'(instr_valid), 32'd1);
    chk("fld_instr",  instr,            32'h4020_8133);
    chk("fld_opcode", 32'(opcode),      32'h33);
    chk("fld_func3",  32'(func3),       32'd0);
    chk("fld_func7",  32'(func7),       32'd1);

    // Redirect in HOLD beats instr_ready
    cyc(0, 0, 0, 1, 1, 32'h20);
    cyc(0, 1, NOP, 0, 0, 0);
    chk("hold_pc",    pc,               32'h20);
    chk("hold_valid", 32'(instr_valid), 32'd1);
    cyc(0, 0, 0, 1, 1, 32'h100);
    chk("redir_req",  32'(imem_req),    32'd1);
    chk("redir_addr", imem_addr,        32'h100);

    // Redirect while request outstanding: old address held, data dropped
    cyc(0, 0, 0, 0, 1, 32'h200);
    chk("flush_addr", imem_addr, 32'h100);
    chk("flush_req",  32'(imem_req), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("flush_addr2", imem_addr, 32'h100);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drop_valid", 32'(instr_valid), 32'd0);
    chk("drop_instr", instr,            NOP);
    chk("drop_addr",  imem_addr,        32'h200);

    // pc wrap at the top of the address space
    cyc(0, 1, NOP, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 1, NOP, 0, 0, 0);
    chk("wrap_pc4", pc_plus4, 32'h0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset mid-request, late ack ignored
    cyc(1, 0, 0, 0, 0, 0);
    chk("rstmid_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("late_valid", 32'(instr_valid), 32'd0);
    chk("late_instr", instr,            NOP);

    // Misaligned redirect halts until reset
    cyc(0, 0, 0, 0, 1, 32'h102);
    chk("mis_flag", 32'(misalign_err), 32'd1);
    chk("mis_req",  32'(imem_req),     32'd0);
    for (int j = 0; j < 3; j++) begin
      cyc(0, 1'($urandom_range(0, 1)), $urandom, 1, 1, 32'h40);
      chk("halt_req",   32'(imem_req),     32'd0);
      chk("halt_mis",   32'(misalign_err), 32'd1);
      chk("halt_valid", 32'(instr_valid),  32'd0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("clr_mis", 32'(misalign_err), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("restart_req",  32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr,     32'h0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [31:0] rp;
      rp = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      cyc(1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)),
          $urandom,
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) == 0),
          rp);
    end
    compare_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ifetch_unit
